// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - pushbutton synchronizer, debouncer and press/release/long-press strobe generator
// Pulses are registered one cycle behind the debounced level so consumers see clean single-cycle strobes.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_button,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_ARM = LW'(LONG_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          held_d;
    logic          long_arm;
    logic [DW-1:0] db_cnt;
    logic [LW-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            held          <= 1'b0;
            held_d        <= 1'b0;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            long_arm      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            s1 <= raw_button;
            s2 <= s1;

            // Any sample agreeing with held restarts the stability window.
            if (s2 == held) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                held   <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end

            held_d <= held;

            if (!held) begin
                hold_cnt <= '0;
            end else if (hold_cnt != LONG_MAX) begin
                hold_cnt <= hold_cnt + LW'(1);
            end

            // Saturation at LONG_MAX means LONG_ARM is passed once per press: no auto-repeat.
            long_arm      <= held && (hold_cnt == LONG_ARM);
            press_pulse   <= held & ~held_d;
            release_pulse <= ~held & held_d;
            long_pulse    <= long_arm & held;
        end
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed bench with window-based reference model for two parameter sets
module tb_btn_conditioner;
    localparam int NMAX = 1024;
    localparam int OFF  = 16;

    logic clk = 1'b0;
    logic reset;
    logic raw_button;
    logic held0, pp0, rp0, lp0;
    logic held1, pp1, rp1, lp1;

    always #5 clk = ~clk;

    btn_conditioner #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(8)) dut0 (
        .clk(clk), .reset(reset), .raw_button(raw_button),
        .held(held0), .press_pulse(pp0), .release_pulse(rp0), .long_pulse(lp0)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(2), .LONG_CYCLES(2)) dut1 (
        .clk(clk), .reset(reset), .raw_button(raw_button),
        .held(held1), .press_pulse(pp1), .release_pulse(rp1), .long_pulse(lp1)
    );

    bit m_raw[NMAX];
    bit m_rst[NMAX];
    bit m_s1[NMAX];
    bit m_s2[NMAX];
    bit m_held[2][NMAX];
    bit m_press[2][NMAX];
    bit m_rel[2][NMAX];
    bit m_long[2][NMAX];

    int n;
    int t0;
    int checks;
    int errors;
    int press_cnt[2], rel_cnt[2], long_cnt[2];
    int press_n[2], rel_n[2], long_n[2], rise_n[2];
    bit prev_h[2];

    function automatic int dbc(input int c);
        return (c == 0) ? 4 : 2;
    endfunction

    function automatic int lgc(input int c);
        return (c == 0) ? 8 : 2;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, n, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Held flips once D consecutive synchronized samples disagree with it and no reset broke the window.
    task automatic run_model();
        bit flip;
        bit stay;
        int d;
        int l;
        if (m_rst[n]) begin
            m_s1[n] = 1'b0;
            m_s2[n] = 1'b0;
            for (int c = 0; c < 2; c++) begin
                m_held[c][n]  = 1'b0;
                m_press[c][n] = 1'b0;
                m_rel[c][n]   = 1'b0;
                m_long[c][n]  = 1'b0;
            end
        end else begin
            m_s1[n] = m_raw[n];
            m_s2[n] = m_s1[n-1];
            for (int c = 0; c < 2; c++) begin
                d = dbc(c);
                l = lgc(c);
                flip = 1'b1;
                for (int j = 1; j <= d; j++)
                    if (m_s2[n-j] == m_held[c][n-1]) flip = 1'b0;
                for (int j = 1; j < d; j++)
                    if (m_rst[n-j]) flip = 1'b0;
                m_held[c][n]  = flip ? !m_held[c][n-1] : m_held[c][n-1];
                m_press[c][n] = m_held[c][n-1] && !m_held[c][n-2];
                m_rel[c][n]   = !m_held[c][n-1] && m_held[c][n-2] && !m_rst[n-1];
                stay = 1'b1;
                for (int m = n - l - 1; m <= n - 1; m++)
                    if (!m_held[c][m]) stay = 1'b0;
                m_long[c][n] = m_press[c][n-l] && stay;
            end
        end
    endtask

    task automatic step(input logic r, input logic rs);
        logic h, p, q, g;
        raw_button = r;
        reset      = rs;
        @(posedge clk);
        m_raw[n] = r;
        m_rst[n] = rs;
        run_model();
        #1;
        for (int c = 0; c < 2; c++) begin
            h = (c == 0) ? held0 : held1;
            p = (c == 0) ? pp0 : pp1;
            q = (c == 0) ? rp0 : rp1;
            g = (c == 0) ? lp0 : lp1;
            check_bit($sformatf("held_c%0d", c), h, m_held[c][n]);
            check_bit($sformatf("press_c%0d", c), p, m_press[c][n]);
            check_bit($sformatf("release_c%0d", c), q, m_rel[c][n]);
            check_bit($sformatf("long_c%0d", c), g, m_long[c][n]);
            check_bit($sformatf("overlap_c%0d", c), (int'(p) + int'(q) + int'(g)) > 1, 1'b0);
            if (h === 1'b1 && !prev_h[c]) rise_n[c] = n;
            prev_h[c] = (h === 1'b1);
            if (p === 1'b1) begin press_cnt[c]++; press_n[c] = n; end
            if (q === 1'b1) begin rel_cnt[c]++;   rel_n[c]   = n; end
            if (g === 1'b1) begin long_cnt[c]++;  long_n[c]  = n; end
        end
        n++;
    endtask

    task automatic mark();
        t0 = n;
        for (int c = 0; c < 2; c++) begin
            press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
            press_n[c] = -1;  rel_n[c] = -1;  long_n[c] = -1; rise_n[c] = -1;
        end
    endtask

    task automatic steps(input logic r, input int k);
        for (int i = 0; i < k; i++) step(r, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < OFF; i++) m_rst[i] = 1'b1;
        n = OFF;
        raw_button = 1'b0;
        reset      = 1'b1;
        mark();

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        check_bit("reset_held0", held0, 1'b0);
        check_bit("reset_press0", pp0, 1'b0);
        steps(1'b0, 4);

        // Clean press held long enough for the long strobe
        mark();
        steps(1'b1, 24);
        check_int("press0_held_rise", rise_n[0] - t0, 5);
        check_int("press0_edge", press_n[0] - t0, 6);
        check_int("press0_count", press_cnt[0], 1);
        check_int("long0_edge", long_n[0] - t0, 14);
        check_int("long0_count", long_cnt[0], 1);
        check_int("press1_edge", press_n[1] - t0, 4);
        check_int("long1_edge", long_n[1] - t0, 6);
        check_int("long1_count", long_cnt[1], 1);

        // Clean release
        mark();
        steps(1'b0, 12);
        check_int("release0_edge", rel_n[0] - t0, 6);
        check_int("release0_count", rel_cnt[0], 1);
        check_int("release1_edge", rel_n[1] - t0, 4);
        check_int("release_press0_count", press_cnt[0], 0);

        // Bounce 1,0,1,0,1 then steady; early release so no long strobe at default settings
        mark();
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        steps(1'b1, 6);
        steps(1'b0, 14);
        check_int("bounce0_press_count", press_cnt[0], 1);
        check_int("bounce0_press_edge", press_n[0] - t0, 10);
        check_int("bounce1_press_edge", press_n[1] - t0, 8);
        check_int("bounce0_release_edge", rel_n[0] - t0, 17);
        check_int("bounce0_long_count", long_cnt[0], 0);

        // Short low glitch while held
        mark();
        steps(1'b1, 20);
        steps(1'b0, 3);
        steps(1'b1, 12);
        check_int("glitch0_press_count", press_cnt[0], 1);
        check_int("glitch0_release_count", rel_cnt[0], 0);
        check_bit("glitch0_held", held0, 1'b1);

        // Reset mid-press, raw still high afterwards
        mark();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check_bit("midreset_held0", held0, 1'b0);
        check_bit("midreset_long0", lp0, 1'b0);
        mark();
        steps(1'b1, 12);
        check_int("postreset0_release_count", rel_cnt[0], 0);
        check_int("postreset0_press_edge", press_n[0] - t0, 6);
        check_int("postreset1_press_edge", press_n[1] - t0, 4);

        // Reset abandons a pending debounce
        steps(1'b0, 12);
        mark();
        steps(1'b1, 3);
        step(1'b0, 1'b1);
        steps(1'b0, 12);
        check_int("abandon0_press_count", press_cnt[0], 0);
        check_int("abandon1_press_count", press_cnt[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized samples required to accept a new button level; legal range is 2 or more.
- REQ-002: Parameter LONG_CYCLES, default 8, is the number of cycles after press_pulse at which long_pulse fires; legal range is 2 or more.
- REQ-003: clk  input  1  is the single clock; all state SHALL update on its rising edge.
- REQ-004: reset  input  1  is a synchronous, active-high reset.
- REQ-005: raw_button  input  1  is the asynchronous, bouncing, active-high pushbutton level.
- REQ-006: held  output  1  is the debounced button level.
- REQ-007: press_pulse  output  1  is a one-cycle strobe on each accepted 0->1 transition of held; it feeds the combination-lock FSM button inputs.
- REQ-008: release_pulse  output  1  is a one-cycle strobe on each accepted 1->0 transition of held.
- REQ-009: long_pulse  output  1  is a one-cycle strobe when held has stayed 1 for LONG_CYCLES cycles after press_pulse.

Function
- REQ-010: raw_button SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
- REQ-011: The debounce counter SHALL increment on every edge where s2 differs from held, and SHALL clear on any edge where s2 equals held.
- REQ-012: On the edge where s2 differs from held and the counter equals DEBOUNCE_CYCLES-1, held SHALL take s2 and the counter SHALL clear.
- REQ-013: Latency: with raw_button first sampled high at edge 0 and held high thereafter, held SHALL rise at edge DEBOUNCE_CYCLES+1 and press_pulse SHALL be high for exactly the cycle after edge DEBOUNCE_CYCLES+2.
- REQ-014: Release SHALL use the same rule and latency; release_pulse SHALL be high for exactly one cycle.
- REQ-015: Glitch rejection: any s2 excursion shorter than DEBOUNCE_CYCLES samples SHALL leave held unchanged and produce no pulse; the counter SHALL restart from 0 after each excursion.
- REQ-016: Pulses SHALL be registered outputs; press_pulse, release_pulse and long_pulse SHALL never be high in the same cycle.
- REQ-017: The hold counter SHALL clear while held=0, and SHALL increment while held=1, saturating at LONG_CYCLES.
- REQ-018: long_pulse SHALL be high for exactly one cycle, LONG_CYCLES cycles after press_pulse, once per press.
- REQ-019: There SHALL be no auto-repeat.
- REQ-020: Release before LONG_CYCLES SHALL produce no long_pulse; the hold counter SHALL clear for the next press.
- REQ-021: Counter widths SHALL be $clog2(parameter+1); arithmetic SHALL be unsigned with no wrap-around.

Reset
- REQ-022: While reset=1, the following SHALL be 0 on the next edge: s1, s2, held, both counters, press_pulse, release_pulse, long_pulse.
- REQ-023: Reset SHALL take priority over all other activity.
- REQ-024: Reset asserted mid-press SHALL produce no release_pulse.
- REQ-025: If raw_button is still high when reset deasserts, that SHALL be treated as a fresh press, with press_pulse following REQ-013 latency counted from the first edge with reset=0.
- REQ-026: Reset asserted mid-debounce SHALL abandon the pending transition.

Verification
- REQ-027: Defaults; raw 0->1 at edge 0, held high -> held=1 after edge 5, press_pulse=1 only in the cycle after edge 6, long_pulse=1 exactly 8 cycles later, then nothing further while held.
- REQ-028: Bounce raw 1,0,1,0,1 at 1-cycle spacing, then steady 1 -> exactly one press_pulse, 6 cycles after the last 0->1; no release_pulse.
- REQ-029: Press held 5 cycles past press_pulse, then raw=0 steady -> release_pulse once at DEBOUNCE_CYCLES+2 after the fall; long_pulse never asserts.
- REQ-030: 3-cycle low glitch while held=1 -> held stays 1; no release_pulse and no second press_pulse.
- REQ-031: reset=1 for 2 cycles while held=1 and raw high -> all outputs 0 with no release_pulse; after reset=0, press_pulse after edge 6 relative to first non-reset edge.
- REQ-032: DEBOUNCE_CYCLES=2, LONG_CYCLES=2 boundary -> press_pulse after edge 4 and long_pulse 2 cycles later; pulses never overlap.
